// File: rtl/bram_queue_reader_if.sv
// Read-side bus bundle for bram_queue_reader: writer pointer, BRAM read port, output stream.
// Latency: none (wires only).
// Backpressure: dout_ready is the downstream ready; qtail carries consumption back to the writer.
// Ports:
//   qhead      writer head pointer         addrb  BRAM read address   doutb  BRAM read data
//   qtail      consumed-tail pointer       dout / dout_valid / dout_ready  output stream
//   flush      discard unconsumed words    error  sticky sequence error
// master = environment (writer, BRAM, consumer), slave = the reader.
interface bram_queue_reader_if #(
  parameter int ADDR_SIZE = 11,
  parameter int DATA_SIZE = 21
);
  logic [ADDR_SIZE-1:0] qhead;
  logic [ADDR_SIZE-1:0] addrb;
  logic [ADDR_SIZE-1:0] qtail;
  logic [DATA_SIZE-1:0] doutb;
  logic [DATA_SIZE-1:0] dout;
  logic                 dout_valid;
  logic                 dout_ready;
  logic                 flush;
  logic                 error;

  modport master (
    output qhead, doutb, dout_ready, flush,
    input  addrb, qtail, dout, dout_valid, error
  );

  modport slave (
    input  qhead, doutb, dout_ready, flush,
    output addrb, qtail, dout, dout_valid, error
  );
endinterface

// File: rtl/bram_queue_reader.sv
// Read controller for a BRAM circular queue: pipelined reads land in a skid FIFO feeding a valid/ready stream.
// Latency: READ_LATENCY+1 cycles from first non-empty cycle to dout_valid; one word per cycle sustained.
// Backpressure: reads are credit-limited so in-flight + buffered words never exceed SKID_DEPTH; nothing is lost.
// Ports: CLK, RESET_N (async, active low), bus (bram_queue_reader_if.slave: qhead/addrb/doutb/qtail/
//   dout/dout_valid/dout_ready/flush/error).
// Optional: define BRAM_READER_CHECK_EN to build the 0,1,2,... data sequence checker driving error.
module bram_queue_reader #(
  parameter int ADDR_SIZE    = 11,
  parameter int DATA_SIZE    = 21,
  parameter int READ_LATENCY = 3
) (
  input  logic               CLK,
  input  logic               RESET_N,
  bram_queue_reader_if.slave bus
);
  localparam int SKID_DEPTH = READ_LATENCY + 2;
  localparam int CW         = $clog2(SKID_DEPTH + 1);
  localparam int IW         = $clog2(SKID_DEPTH);

  logic [ADDR_SIZE-1:0]    rd_ptr;
  logic [ADDR_SIZE-1:0]    qtail_q;
  logic [READ_LATENCY-1:0] tag;
  logic [DATA_SIZE-1:0]    skid [SKID_DEPTH];
  logic [IW-1:0]           wr_idx;
  logic [IW-1:0]           rd_idx;
  logic [CW-1:0]           occ;
  logic [DATA_SIZE-1:0]    dout_q;
  logic                    dout_valid_q;

  logic [CW-1:0]           inflight;
  logic [CW-1:0]           occ_after_pop;
  logic [CW-1:0]           occ_nxt;
  logic [IW-1:0]           rd_idx_nxt;
  logic                    issue;
  logic                    push;
  logic                    pop;

  function automatic logic [IW-1:0] idx_inc(input logic [IW-1:0] idx);
    return (idx == IW'(SKID_DEPTH - 1)) ? '0 : idx + IW'(1);
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight = inflight + CW'(tag[i]);
    end
  end

  // A read is only launched if a skid slot is guaranteed for its data.
  assign issue = (rd_ptr != bus.qhead) && ((inflight + occ) < CW'(SKID_DEPTH)) && !bus.flush;
  assign push  = tag[READ_LATENCY-1] && !bus.flush;
  assign pop   = dout_valid_q && bus.dout_ready && !bus.flush;

  assign occ_after_pop = occ - CW'(pop);
  assign occ_nxt       = occ_after_pop + CW'(push);
  assign rd_idx_nxt    = pop ? idx_inc(rd_idx) : rd_idx;

  always_ff @(posedge CLK) begin
    if (push) begin
      skid[wr_idx] <= bus.doutb;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rd_ptr       <= '0;
      qtail_q      <= '0;
      tag          <= '0;
      wr_idx       <= '0;
      rd_idx       <= '0;
      occ          <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else if (bus.flush) begin
      // Everything issued or buffered is abandoned; the reader resynchronises to the writer.
      rd_ptr       <= bus.qhead;
      qtail_q      <= bus.qhead;
      tag          <= '0;
      wr_idx       <= '0;
      rd_idx       <= '0;
      occ          <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      if (issue) begin
        rd_ptr <= rd_ptr + ADDR_SIZE'(1);
      end
      if (pop) begin
        qtail_q <= qtail_q + ADDR_SIZE'(1);
      end
      tag[0] <= issue;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag[i] <= tag[i-1];
      end
      if (push) begin
        wr_idx <= idx_inc(wr_idx);
      end
      rd_idx <= rd_idx_nxt;
      occ    <= occ_nxt;
      // Registered head: from the arriving word when the FIFO would otherwise be empty,
      // else from the entry that becomes the head after this edge's pop.
      if (occ_after_pop == '0) begin
        if (push) begin
          dout_q <= bus.doutb;
        end
      end else begin
        dout_q <= skid[rd_idx_nxt];
      end
      dout_valid_q <= (occ_nxt != '0);
    end
  end

  // The credit rule keeps occupancy within SKID_DEPTH; a push into a full FIFO means that rule broke.
  always_ff @(posedge CLK) begin
    if (RESET_N && !bus.flush) begin
      assert (!(push && !pop && (occ == CW'(SKID_DEPTH))));
    end
  end

  assign bus.addrb      = rd_ptr;
  assign bus.qtail      = qtail_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;

`ifdef BRAM_READER_CHECK_EN
  logic [DATA_SIZE-1:0] expected;
  logic                 error_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      expected <= '0;
      error_q  <= 1'b0;
    end else if (pop) begin
      if (dout_q == expected) begin
        expected <= expected + DATA_SIZE'(1);
      end else begin
        error_q <= 1'b1;
      end
    end
  end

  assign bus.error = error_q;
`else
  assign bus.error = 1'b0;
`endif
endmodule

// File: tb/tb_bram_queue_reader.sv
`timescale 1ns/1ps
module tb_bram_queue_reader;
  localparam int AW    = 11;
  localparam int DW    = 21;
  localparam int RL    = 3;
  localparam int DEPTH = 1 << AW;
`ifdef BRAM_READER_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RESET_N;
  always #5 CLK = ~CLK;

  bram_queue_reader_if #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) bus ();

  bram_queue_reader #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .READ_LATENCY(RL)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  // BRAM model: data for the address presented in cycle N appears in cycle N+RL.
  logic [DW-1:0] mem  [DEPTH];
  logic [DW-1:0] pipe [RL];
  always @(posedge CLK) begin
    pipe[0] <= mem[bus.addrb];
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.doutb = pipe[RL-1];

  int            checks   = 0;
  int            failures = 0;
  logic [DW-1:0] sb [$];
  logic [DW-1:0] data_ctr = '0;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    mem[bus.qhead] = d;
    bus.qhead = bus.qhead + AW'(1);
    sb.push_back(d);
  endtask

  task automatic push_next();
    push_word(data_ctr);
    data_ctr = data_ctr + DW'(1);
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    bus.qhead = '0;
    bus.flush = 1'b0;
    bus.dout_ready = 1'b0;
    repeat (3) tick();
    @(negedge CLK);
    checks++;
    if (bus.addrb !== '0 || bus.qtail !== '0 || bus.dout_valid !== 1'b0 || bus.dout !== '0 || bus.error !== 1'b0) begin
      failures++;
      $display("FAIL reset_values addrb=%0d qtail=%0d dout_valid=%0b dout=%0d error=%0b required all 0",
               bus.addrb, bus.qtail, bus.dout_valid, bus.dout, bus.error);
    end
    tick();
    RESET_N = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      checks++;
      if (bus.addrb !== '0 || bus.dout_valid !== 1'b0 || bus.qtail !== '0) begin
        failures++;
        $display("FAIL idle_empty cycle=%0d addrb=%0d dout_valid=%0b qtail=%0d required 0/0/0",
                 c, bus.addrb, bus.dout_valid, bus.qtail);
      end
      tick();
    end
  endtask

  task automatic test_latency();
    logic [DW-1:0] exp_d;
    bus.dout_ready = 1'b1;
    for (int i = 0; i < 10; i++) push_next();
    for (int c = 0; c < 16; c++) begin
      @(negedge CLK);
      checks++;
      if (bus.dout_valid !== ((c >= 4 && c <= 13) ? 1'b1 : 1'b0)) begin
        failures++;
        $display("FAIL latency_valid cycle=%0d dout_valid=%0b required %0b", c, bus.dout_valid, (c >= 4 && c <= 13));
      end
      if (bus.dout_valid && bus.dout_ready && !bus.flush) begin
        checks++;
        exp_d = (sb.size() > 0) ? sb.pop_front() : 'x;
        if (bus.dout !== exp_d) begin
          failures++;
          $display("FAIL latency_data cycle=%0d dout=%0d required %0d", c, bus.dout, exp_d);
        end
      end
      tick();
    end
    @(negedge CLK);
    checks++;
    if (bus.qtail !== AW'(10) || sb.size() != 0) begin
      failures++;
      $display("FAIL latency_tail qtail=%0d left=%0d required qtail=10 left=0", bus.qtail, sb.size());
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] exp_d;
    logic [DW-1:0] first;
    int            n = 0;
    bus.dout_ready = 1'b0;
    for (int i = 0; i < 50; i++) push_next();
    first = sb[0];
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (c >= 4) begin
        checks++;
        if (bus.dout_valid !== 1'b1 || bus.dout !== first) begin
          failures++;
          $display("FAIL stall_hold cycle=%0d dout_valid=%0b dout=%0d required 1/%0d", c, bus.dout_valid, bus.dout, first);
        end
      end
      tick();
    end
    @(negedge CLK);
    checks++;
    if (bus.addrb !== AW'(15) || bus.qtail !== AW'(10)) begin
      failures++;
      $display("FAIL stall_credit addrb=%0d qtail=%0d required 15/10", bus.addrb, bus.qtail);
    end
    tick();
    bus.dout_ready = 1'b1;
    for (int c = 0; c < 200 && sb.size() > 0; c++) begin
      @(negedge CLK);
      if (bus.dout_valid && bus.dout_ready && !bus.flush) begin
        checks++;
        n++;
        exp_d = sb.pop_front();
        if (bus.dout !== exp_d) begin
          failures++;
          $display("FAIL drain_data n=%0d dout=%0d required %0d", n, bus.dout, exp_d);
        end
      end
      tick();
    end
    @(negedge CLK);
    checks++;
    if (n != 50 || bus.qtail !== AW'(60) || bus.dout_valid !== 1'b0) begin
      failures++;
      $display("FAIL drain_count transfers=%0d qtail=%0d dout_valid=%0b required 50/60/0", n, bus.qtail, bus.dout_valid);
    end
    tick();
  endtask

  task automatic test_reset_midstream();
    logic [DW-1:0] exp_d;
    bus.dout_ready = 1'b1;
    for (int i = 0; i < 20; i++) push_next();
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      if (bus.dout_valid && bus.dout_ready && !bus.flush) begin
        checks++;
        exp_d = sb.pop_front();
        if (bus.dout !== exp_d) begin
          failures++;
          $display("FAIL midreset_data dout=%0d required %0d", bus.dout, exp_d);
        end
      end
      tick();
    end
    #2;
    RESET_N = 1'b0;
    #1;
    checks++;
    if (bus.addrb !== '0 || bus.qtail !== '0 || bus.dout_valid !== 1'b0 || bus.dout !== '0 || bus.error !== 1'b0) begin
      failures++;
      $display("FAIL async_reset addrb=%0d qtail=%0d dout_valid=%0b dout=%0d error=%0b required all 0",
               bus.addrb, bus.qtail, bus.dout_valid, bus.dout, bus.error);
    end
    bus.qhead = '0;
    sb.delete();
    data_ctr = '0;
    tick();
    RESET_N = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge CLK);
      checks++;
      if (bus.dout_valid !== 1'b0 || bus.addrb !== '0) begin
        failures++;
        $display("FAIL post_reset_idle cycle=%0d dout_valid=%0b addrb=%0d required 0/0", c, bus.dout_valid, bus.addrb);
      end
      tick();
    end
  endtask

  task automatic test_error();
    logic [DW-1:0] exp_d;
    logic          exp_err;
    int            n = 0;
    bus.dout_ready = 1'b1;
    for (int i = 0; i < 12; i++) push_word((i == 7) ? DW'(21'h1ABCD) : DW'(i));
    data_ctr = DW'(12);
    for (int c = 0; c < 60 && sb.size() > 0; c++) begin
      @(negedge CLK);
      exp_err = CHECK_EN && (n >= 8);
      checks++;
      if (bus.error !== exp_err) begin
        failures++;
        $display("FAIL error_flag transfers=%0d error=%0b required %0b", n, bus.error, exp_err);
      end
      if (bus.dout_valid && bus.dout_ready && !bus.flush) begin
        checks++;
        n++;
        exp_d = sb.pop_front();
        if (bus.dout !== exp_d) begin
          failures++;
          $display("FAIL error_data n=%0d dout=%0d required %0d", n, bus.dout, exp_d);
        end
      end
      tick();
    end
    repeat (3) tick();
    @(negedge CLK);
    checks++;
    if (sb.size() != 0 || bus.error !== CHECK_EN) begin
      failures++;
      $display("FAIL error_sticky left=%0d error=%0b required 0/%0b", sb.size(), bus.error, CHECK_EN);
    end
    tick();
  endtask

  task automatic test_flush();
    logic [DW-1:0] exp_d;
    logic [AW-1:0] qh;
    bus.dout_ready = 1'b0;
    for (int i = 0; i < 10; i++) push_next();
    repeat (5) tick();
    // Now 3 reads are in flight and 2 words sit in the skid FIFO.
    bus.flush = 1'b1;
    bus.dout_ready = 1'b1;
    qh = bus.qhead;
    tick();
    bus.flush = 1'b0;
    sb.delete();
    for (int c = 0; c < 7; c++) begin
      @(negedge CLK);
      checks++;
      if (bus.dout_valid !== 1'b0 || bus.qtail !== qh || bus.addrb !== qh) begin
        failures++;
        $display("FAIL flush_state cycle=%0d dout_valid=%0b qtail=%0d addrb=%0d required 0/%0d/%0d",
                 c, bus.dout_valid, bus.qtail, bus.addrb, qh, qh);
      end
      tick();
    end
    for (int i = 0; i < 3; i++) push_next();
    for (int c = 0; c < 40 && sb.size() > 0; c++) begin
      @(negedge CLK);
      if (bus.dout_valid && bus.dout_ready && !bus.flush) begin
        checks++;
        exp_d = sb.pop_front();
        if (bus.dout !== exp_d) begin
          failures++;
          $display("FAIL post_flush_data dout=%0d required %0d", bus.dout, exp_d);
        end
      end
      tick();
    end
    @(negedge CLK);
    checks++;
    if (sb.size() != 0 || bus.qtail !== qh + AW'(3)) begin
      failures++;
      $display("FAIL post_flush_tail left=%0d qtail=%0d required 0/%0d", sb.size(), bus.qtail, qh + AW'(3));
    end
    tick();
  endtask

  task automatic test_wrap();
    logic [DW-1:0] exp_d;
    logic [AW-1:0] exp_tail;
    int            pushed = 0;
    bus.dout_ready = 1'b0;
    bus.qhead = AW'(DEPTH - 8);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    for (int c = 0; c < 600 && (pushed < 40 || sb.size() > 0); c++) begin
      bus.dout_ready = 1'($urandom_range(0, 1));
      if (pushed < 40 && $urandom_range(0, 1) == 1) begin
        push_next();
        pushed++;
      end
      @(negedge CLK);
      exp_tail = bus.qhead - AW'(sb.size());
      checks++;
      if (bus.qtail !== exp_tail || (bus.qhead + AW'(1)) == bus.qtail) begin
        failures++;
        $display("FAIL wrap_tail cycle=%0d qtail=%0d required %0d (writer full must not appear)", c, bus.qtail, exp_tail);
      end
      if (bus.dout_valid && bus.dout_ready && !bus.flush) begin
        checks++;
        exp_d = sb.pop_front();
        if (bus.dout !== exp_d) begin
          failures++;
          $display("FAIL wrap_data cycle=%0d dout=%0d required %0d", c, bus.dout, exp_d);
        end
      end
      tick();
    end
    @(negedge CLK);
    checks++;
    if (pushed != 40 || sb.size() != 0 || bus.qtail !== AW'(32)) begin
      failures++;
      $display("FAIL wrap_done pushed=%0d left=%0d qtail=%0d required 40/0/32", pushed, sb.size(), bus.qtail);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latency();
    test_backpressure();
    test_reset_midstream();
    test_error();
    test_flush();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bram_queue_reader.md
# bram_queue_reader

Read-side controller for a BRAM-backed circular queue whose write side owns `qhead`. It issues pipelined reads on the BRAM's read port, tracks words in flight across the fixed read latency, and lands them in a small skid FIFO. That FIFO presents a valid/ready stream downstream, so full-rate draining and arbitrary backpressure are both supported. It returns a consumed-tail pointer to the writer for its full check (`qhead+1 == qtail`).

## Interface
- `ADDR_SIZE`, 11, queue address width; depth 2^ADDR_SIZE, one slot always unused.
- `DATA_SIZE`, 21, word width.
- `READ_LATENCY`, 3, BRAM clocks from `addrb` to valid `doutb`; legal range 1..8.
- `CLK`  in  1  sole clock, rising edge.
- `RESET_N`  in  1  asynchronous, active-low reset.
- `qhead`  in  ADDR_SIZE  writer's head pointer, synchronous to CLK; next slot to be written.
- `addrb`  out  ADDR_SIZE  BRAM read address (= `rd_ptr`).
- `doutb`  in  DATA_SIZE  BRAM read data.
- `qtail`  out  ADDR_SIZE  consumed-tail pointer returned to the writer.
- `dout`  out  DATA_SIZE  head word of the skid FIFO.
- `dout_valid`  out  1  `dout` holds a word.
- `dout_ready`  in  1  downstream accepts; transfer = valid & ready.
- `flush`  in  1  synchronous: discard everything not yet consumed.
- `error`  out  1  sticky sequence error (see Configuration).

## Operation
- State: `rd_ptr`, `qtail`, in-flight tag shift register `tag[READ_LATENCY-1:0]`, skid FIFO with depth `SKID_DEPTH = READ_LATENCY+2` and occupancy `occ`.
- Reset values: `rd_ptr = qtail = 0`, all tags 0, `occ = 0`, `dout_valid = 0`, `dout = 0`, `addrb = 0`, `error = 0`.
- `inflight` is the popcount of `tag`.
- Issue condition: `issue = (rd_ptr != qhead) && (inflight + occ < SKID_DEPTH) && !flush`.
- On an issue edge, `rd_ptr` increments. `tag` shifts every edge, with `tag[0] <= issue`.
- When `tag[READ_LATENCY-1]` is high, `doutb` is written into the skid FIFO at that edge.
- A transfer pops the FIFO and increments `qtail`. A push and a pop in the same edge leave `occ` unchanged.
- The FIFO can never overflow, by construction of the credit rule. Overflow is an assertion failure.
- Pointers wrap modulo 2^ADDR_SIZE. Compare with plain equality only; there is no extra wrap bit.
- Empty: `rd_ptr == qhead`, so no issue. The writer detects full from `qtail`.
- `qtail` is never ahead of `rd_ptr`. The distance `rd_ptr - qtail` (mod) equals `inflight + occ`.
- Flush edge:
  - clears all tags and `occ`;
  - sets `rd_ptr <= qhead` and `qtail <= qhead`;
  - drops `dout_valid` at the next cycle;
  - performs no transfer in the flush cycle, even if `dout_ready` is high.
- Asynchronous reset mid-stream returns every register to its reset value immediately. In-flight BRAM data is ignored afterwards because all tags are 0.

## Timing
- A read issues in cycle 0, the first cycle in which `qhead != rd_ptr`. `addrb` is registered, so the address is presented from cycle 0.
- `doutb` is valid in cycle READ_LATENCY and captured at its closing edge. `dout_valid` rises in cycle READ_LATENCY+1.
- With `dout_ready` held high and the queue non-empty, one word transfers per cycle indefinitely.
- `qtail` updates at the edge closing the transfer cycle.
- `dout` and `dout_valid` are registered. `dout` is stable while `dout_valid && !dout_ready`.
- After `dout_ready` deasserts, issue stops once `inflight + occ` reaches SKID_DEPTH. No word is ever lost.

## Configuration
- `BRAM_READER_CHECK_EN` defined:
  - An internal `expected` counter (DATA_SIZE bits, reset 0) is compared with `dout` on each transfer.
  - On a match, `expected` increments.
  - On a mismatch, `error` sets and stays set until reset.
  - `flush` does not alter `expected`.
  - The writer's data pattern must be `din` = 0,1,2,… matched to slot order.
- Not defined: no checker logic is synthesized and `error` is tied to 0.

## Test plan
- Reset, then hold `qhead` at 0 for 20 cycles -> `addrb = 0` throughout, `dout_valid = 0`, `qtail = 0`.
- Writer pushes 0..9 (`qhead` reaches 10) with `dout_ready = 1` -> first `dout_valid` 4 cycles after `qhead` = 1. Then 10 consecutive transfers of 0..9 with no gaps, and `qtail = 10`.
- `dout_ready = 0` with 50 words queued -> exactly 5 words issued (`rd_ptr = 5`). Release ready -> words 0..49 in order, none duplicated or lost.
- `ADDR_SIZE = 4`, push and drain 40 words with random `dout_ready` -> ordered data across the 15→0 wrap; the writer never sees full falsely.
- Flush with 3 words in flight and 2 in the skid FIFO -> the next cycle has `dout_valid = 0`, and `rd_ptr = qtail = qhead`. New pushes are then read normally.
- With `BRAM_READER_CHECK_EN`: corrupt slot 7 -> `error` rises after transfer 7 and remains 1. Asserting `RESET_N` low mid-stream clears all outputs asynchronously.
